parity_check_stream: RTL and testbench
======================================

Name: parity_check_stream

Overview:
- Streaming, parametrised parity checker for framed data words carrying one parity bit.
- Sits between a receive front-end (UART/serial deserialiser) and downstream consumers.
- Supports per-beat even/odd mode and a valid/ready handshake with one register stage.
- Keeps a saturating error counter and a sticky error flag for status readback.

Parameters:
- DATA_W, 8, payload width in bits (legal range 1..64).
- CNT_W, 16, width of the error counter.
- DEFAULT_ODD, 0, parity mode in effect while mode_ovr=0 (0 = even, 1 = odd).

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst_n, input, 1, reset, asynchronous, active-low.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- in_data, input, DATA_W, payload.
- in_parity, input, 1, received parity bit.
- mode_ovr, input, 1, 1 = use mode_odd for this beat instead of DEFAULT_ODD.
- mode_odd, input, 1, per-beat mode when mode_ovr=1 (1 = odd).
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, registered payload.
- out_err, output, 1, parity error flag for this beat.
- err_sticky, output, 1, set on any error; cleared only by clr.
- err_count, output, CNT_W, saturating count of errored beats.
- clr, input, 1, synchronous clear of err_sticky and err_count.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_err=0, err_sticky=0, err_count=0. in_ready=1 once reset is released.
- Accept rule: beat accepted when in_valid && in_ready. in_ready = out_ready || !out_valid (combinational, no bubble).
- Error function: odd = mode_ovr ? mode_odd : DEFAULT_ODD. err = (^{in_parity, in_data}) ^ odd.
  - Even mode: error when the total count of ones is odd.
  - Odd mode: error when the total count of ones is even.
- Latency: one cycle. An accepted beat appears on out_data/out_err the next cycle with out_valid=1.
- Output hold:
  - While out_valid && !out_ready, out_data and out_err are held stable and in_ready=0.
  - in_valid/in_data are not sampled while stalled.
- Simultaneous: output consumed and new input accepted in the same cycle → output register is reloaded and out_valid stays 1 (full throughput, 1 beat/cycle).
- No input accepted while the output is consumed → out_valid falls to 0 the next cycle. out_data is held; its value does not matter while out_valid=0.
- Counter update on each accepted beat with err=1:
  - err_count increments by 1, saturating at 2^CNT_W-1 (no wrap).
  - err_sticky sets to 1.
- Counting happens at acceptance, not at output, so stalled beats are counted exactly once.
- clr priority: clr=1 forces err_count=0 and err_sticky=0.
  - If an errored beat is accepted in the same cycle, the result is err_count=1 and err_sticky=1 (clear then count).
  - clr does not affect the data path.
- Reset mid-stream: the in-flight output beat is discarded (out_valid=0). Counters return to 0.
- DATA_W=1: reduction covers 2 bits; no special case.

Decomposition:
- parity_defs.vh:
  - mode constants PAR_EVEN=1'b0 and PAR_ODD=1'b1.
  - saturation-max helper macro for CNT_W.
- Sub-module parity_calc (parameter DATA_W):
  - Purely combinational.
  - Inputs data, parity_bit, odd; output err.
  - Instantiated once; reusable by the future TX parity generator.

Test Plan:
- Even mode, in_data=8'hA5, in_parity=0, out_ready=1 → next cycle out_valid=1, out_data=8'hA5, out_err=0; err_count=0.
- Even mode, in_data=8'h01, in_parity=0 → out_err=1, err_count=1, err_sticky=1. Then mode_ovr=1, mode_odd=1, in_data=8'h01, in_parity=0 → out_err=0, err_count stays 1.
- Backpressure: out_ready=0 for 3 cycles with an errored beat held → out_data/out_err stable, in_ready=0, err_count increments only once. Then out_ready=1 with in_valid=1 every cycle → one beat per cycle, no gaps.
- Saturation with CNT_W=2: 5 errored beats → err_count sequence 1, 2, 3, 3, 3.
- clr asserted in the same cycle as an errored beat accepted, with err_count=3 → err_count=1, err_sticky=1. clr alone → err_count=0, err_sticky=0.
- Assert rst_n=0 asynchronously while out_valid=1 and err_count=2 → out_valid=0, err_count=0, err_sticky=0 immediately without a clock edge. Release → in_ready=1.

Source files
------------

// File: rtl/parity_check_stream_pkg.sv
// parity_check_stream_pkg: shared parity mode encoding and counter helpers
package parity_check_stream_pkg;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    // Next value of a saturating counter given its current value and maximum
    function automatic logic [63:0] sat_inc(input logic [63:0] cur, input logic [63:0] max);
        return (cur == max) ? cur : cur + 64'd1;
    endfunction

endpackage

// File: rtl/parity_check_stream_calc.sv
// parity_calc: combinational parity check of a data word plus its parity bit
module parity_calc
    import parity_check_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic              parity_bit,
    input  par_mode_e         odd,
    output logic              err
);

    assign err = (^{parity_bit, data}) ^ logic'(odd);

endmodule

// File: rtl/parity_check_stream.sv
// parity_check_stream: one-stage registered parity checker with error status
module parity_check_stream
    import parity_check_stream_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter bit DEFAULT_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              mode_ovr,
    input  logic              mode_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    par_mode_e mode;
    logic      beat_err;
    logic      accept;
    logic      count_hit;

    assign mode      = par_mode_e'(mode_ovr ? mode_odd : DEFAULT_ODD);
    assign in_ready  = out_ready || !out_valid;
    assign accept    = in_valid && in_ready;
    assign count_hit = accept && beat_err;

    parity_calc #(.DATA_W(DATA_W)) u_calc (
        .data       (in_data),
        .parity_bit (in_parity),
        .odd        (mode),
        .err        (beat_err)
    );

    // Output register: load on accept, drain when consumed with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_err   <= beat_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Error status counts at acceptance; clr wipes first, then the same-cycle beat counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_count  <= count_hit ? CNT_W'(1) : '0;
            err_sticky <= count_hit;
        end else if (count_hit) begin
            err_count  <= CNT_W'(sat_inc(64'(err_count), 64'(CNT_MAX)));
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_check_stream.sv
// tb_parity_check_stream: randomized scoreboard bench for parity_check_stream
module tb_parity_check_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_parity = 1'b0;
    logic              mode_ovr = 1'b0;
    logic              mode_odd = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;
    logic              clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cnt = 0;
    bit   exp_sticky = 1'b0;

    parity_check_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEFAULT_ODD(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .mode_ovr   (mode_ovr),
        .mode_odd   (mode_odd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference error rule: even mode wants an even number of ones, odd mode an odd number
    function automatic bit ref_err(input logic [DATA_W-1:0] d, input logic p, input logic ovr, input logic odd);
        int  ones;
        bit  want_odd;
        ones     = $countones({p, d});
        want_odd = ovr ? odd : 1'b0;
        return want_odd ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    // Monitor/scoreboard: mid-cycle check of outputs, then predict the coming edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit empty;
                bit acc;
                bit e;
                empty = (exp_q.size() == 0);
                chk("out_valid", 64'(out_valid), 64'(!empty));
                chk("in_ready", 64'(in_ready), 64'(out_ready || empty));
                chk("err_count", 64'(err_count), 64'(exp_cnt));
                chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
                if (out_valid && !empty) begin
                    chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                    chk("out_err", 64'(out_err), 64'(exp_q[0].err));
                end
                acc = in_valid && (out_ready || empty);
                e   = ref_err(in_data, in_parity, mode_ovr, mode_odd);
                if (!empty && out_ready) void'(exp_q.pop_front());
                if (acc) exp_q.push_back('{data: in_data, err: e});
                if (clr) begin
                    exp_cnt    = (acc && e) ? 1 : 0;
                    exp_sticky = acc && e;
                end else if (acc && e) begin
                    exp_cnt    = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
                    exp_sticky = 1'b1;
                end
            end
        end
    end

    task automatic beat(input logic v, input logic [DATA_W-1:0] d, input logic p,
                        input logic ovr, input logic odd, input logic ordy, input logic c);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_parity = p;
        mode_ovr  = ovr;
        mode_odd  = odd;
        out_ready = ordy;
        clr       = c;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_err_sticky", 64'(err_sticky), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        beat(1, 8'hA5, 0, 0, 0, 1, 0);
        beat(1, 8'h01, 0, 0, 0, 1, 0);
        beat(1, 8'h01, 0, 1, 1, 1, 0);
        beat(0, 8'h00, 0, 0, 0, 1, 0);
        beat(1, 8'h80, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) beat(1, 8'h07, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) beat(1, DATA_W'($urandom), 1'($urandom), 0, 0, 1, 0);
        beat(0, 8'h00, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) beat(1, 8'h01, 0, 0, 0, 1, 0);
        beat(1, 8'h01, 0, 0, 0, 1, 1);
        beat(0, 8'h00, 0, 0, 0, 1, 1);
        beat(1, 8'h03, 1, 1, 0, 1, 0);

        for (int i = 0; i < 400; i++)
            beat(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));

        beat(0, 8'h00, 0, 0, 0, 1, 1);
        beat(1, 8'h01, 0, 0, 0, 1, 0);
        beat(1, 8'h01, 0, 0, 0, 1, 0);
        beat(0, 8'h00, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_err_count", 64'(err_count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_err_count", 64'(err_count), 64'd0);
        chk("async_rst_err_sticky", 64'(err_sticky), 64'd0);
        exp_q.delete();
        exp_cnt    = 0;
        exp_sticky = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 40; i++)
            beat(1'($urandom), DATA_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'b0);
        beat(0, 8'h00, 0, 0, 0, 1, 0);
        beat(0, 8'h00, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
